// File: rtl/arith_pkg.sv
// Shared types and helpers for the sliced arithmetic blocks.
package arith_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} serial_state_t;

   function automatic int num_slices(input int width, input int chunk);
      return width / chunk;
   endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational slice subtractor: {bout, diff} = a - b - bin.
module sub_slice #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   // One guard bit on top captures the borrow as the wrapped MSB.
   assign {bout, diff} = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one CHUNK-bit slice per cycle, LSB slice first.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | one slice per cycle, borrow carried in borrow_r
// DONE  | result presented, held until out_ready
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int NS = num_slices(WIDTH, CHUNK);
   localparam int IW = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NS - 1);

   generate
      if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
         $error("serial_subtractor: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
      end
   endgenerate

   serial_state_t    state;
   serial_state_t    state_n;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] diff_r;
   logic             borrow_r;
   logic             bout_r;
   logic             ovf_r;
   logic [IW-1:0]    idx;
   logic             last;
   int unsigned      base;
   logic [CHUNK-1:0] slice_a;
   logic [CHUNK-1:0] slice_b;
   logic [CHUNK-1:0] slice_d;
   logic             borrow_n;

   assign base    = int'(idx) * CHUNK;
   assign slice_a = a_r[base +: CHUNK];
   assign slice_b = b_r[base +: CHUNK];
   assign last    = (idx == LAST_IDX);

   sub_slice #(.WIDTH(CHUNK)) u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .bin  (borrow_r),
      .diff (slice_d),
      .bout (borrow_n)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (in_valid) state_n = CALC;
         CALC:    if (last) state_n = DONE;
         DONE:    if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_r      <= '0;
         b_r      <= '0;
         diff_r   <= '0;
         borrow_r <= 1'b0;
         bout_r   <= 1'b0;
         ovf_r    <= 1'b0;
         idx      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r      <= a;
                  b_r      <= b;
                  borrow_r <= bin;
                  idx      <= '0;
               end
            end
            CALC: begin
               diff_r[base +: CHUNK] <= slice_d;
               borrow_r              <= borrow_n;
               bout_r                <= borrow_n;
               if (last) begin
                  // The top slice's MSB is the result sign bit.
                  ovf_r <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                           (slice_d[CHUNK-1] != a_r[WIDTH-1]);
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign diff      = diff_r;
   assign bout      = bout_r;
   assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor across CHUNK = 1, 2, 4, 8 with WIDTH = 8.
module tb_serial_subtractor;

   typedef struct packed {
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid [4];
   logic       in_ready [4];
   logic [7:0] op_a     [4];
   logic [7:0] op_b     [4];
   logic       op_bin   [4];
   logic       out_valid[4];
   logic       out_ready[4];
   logic [7:0] diff     [4];
   logic       bout     [4];
   logic       ovf      [4];

   exp_t exp_q[4][$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   // Index k -> CHUNK: 0->1, 1->2, 2->4, 3->8.
   localparam int NSL[4] = '{8, 4, 2, 1};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_subtractor #(.WIDTH(8), .CHUNK(1)) u_c1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(op_a[0]), .b(op_b[0]), .bin(op_bin[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .diff(diff[0]), .bout(bout[0]), .ovf(ovf[0]));
   serial_subtractor #(.WIDTH(8), .CHUNK(2)) u_c2 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(op_a[1]), .b(op_b[1]), .bin(op_bin[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .diff(diff[1]), .bout(bout[1]), .ovf(ovf[1]));
   serial_subtractor #(.WIDTH(8), .CHUNK(4)) u_c4 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .a(op_a[2]), .b(op_b[2]), .bin(op_bin[2]), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .diff(diff[2]), .bout(bout[2]), .ovf(ovf[2]));
   serial_subtractor #(.WIDTH(8), .CHUNK(8)) u_c8 (
      .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
      .a(op_a[3]), .b(op_b[3]), .bin(op_bin[3]), .out_valid(out_valid[3]),
      .out_ready(out_ready[3]), .diff(diff[3]), .bout(bout[3]), .ovf(ovf[3]));

   function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic bi);
      exp_t e;
      int   r;
      r      = int'(av) - int'(bv) - int'(bi);
      e.diff = 8'(r);
      e.bout = (r < 0);
      e.ovf  = (av[7] != bv[7]) && (e.diff[7] != av[7]);
      return e;
   endfunction

   // Drives one operand set at the current negedge; returns the accept cycle.
   task automatic send(input int k, input logic [7:0] av, input logic [7:0] bv,
                       input logic bi, output int c0);
      int n = 0;
      while (!in_ready[k] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready[k]) begin
         checks++;
         failures++;
         $display("FAIL send_timeout k=%0d in_ready=%b required=1", k, in_ready[k]);
      end
      in_valid[k] = 1'b1;
      op_a[k]     = av;
      op_b[k]     = bv;
      op_bin[k]   = bi;
      c0          = cyc;
      exp_q[k].push_back(model(av, bv, bi));
      @(negedge clk);
      in_valid[k] = 1'b0;
      op_a[k]     = 8'($urandom);
      op_b[k]     = 8'($urandom);
      op_bin[k]   = 1'($urandom);
   endtask

   task automatic wait_valid(input int k, output int c);
      int n = 0;
      while (!out_valid[k] && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid[k]) begin
         checks++;
         failures++;
         $display("FAIL wait_valid_timeout k=%0d out_valid=%b required=1", k, out_valid[k]);
      end
      c = cyc;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_valid[k]  = 1'b1;
         out_ready[k] = 1'b1;
         op_a[k]      = 8'hAA;
         op_b[k]      = 8'h55;
         op_bin[k]    = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++) in_valid[k] = 1'b0;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks += 3;
         if (in_ready[k] !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready k=%0d got=%b exp=1", k, in_ready[k]);
         end
         if (out_valid[k] !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid k=%0d got=%b exp=0", k, out_valid[k]);
         end
         if ({diff[k], bout[k], ovf[k]} !== 10'h0) begin
            failures++;
            $display("FAIL reset_outputs k=%0d got=%h/%b/%b exp=00/0/0", k, diff[k], bout[k], ovf[k]);
         end
      end
   endtask

   task automatic test_basic();
      int   c0;
      exp_t e;
      send(2, 8'h35, 8'h12, 1'b0, c0);
      while (cyc <= c0 + 3) begin
         checks += 2;
         if (in_ready[2] !== 1'b0) begin
            failures++;
            $display("FAIL basic_in_ready cyc=%0d got=%b exp=0", cyc - c0, in_ready[2]);
         end
         if (out_valid[2] !== (cyc == c0 + 3)) begin
            failures++;
            $display("FAIL basic_latency cyc=%0d out_valid=%b exp=%b", cyc - c0, out_valid[2], cyc == c0 + 3);
         end
         if (cyc < c0 + 3) @(negedge clk);
         else break;
      end
      e = exp_q[2].pop_front();
      checks++;
      if ({diff[2], bout[2], ovf[2]} !== {e.diff, e.bout, e.ovf}) begin
         failures++;
         $display("FAIL basic_result got=%h/%b/%b exp=%h/%b/%b", diff[2], bout[2], ovf[2], e.diff, e.bout, e.ovf);
      end
      @(negedge clk);
   endtask

   task automatic test_vectors();
      logic [7:0] va[4] = '{8'h10, 8'h00, 8'h80, 8'h7F};
      logic [7:0] vb[4] = '{8'h01, 8'h01, 8'h01, 8'hFF};
      int   c0, c;
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         send(2, va[i], vb[i], 1'b0, c0);
         wait_valid(2, c);
         e = exp_q[2].pop_front();
         checks++;
         if ({diff[2], bout[2], ovf[2]} !== {e.diff, e.bout, e.ovf}) begin
            failures++;
            $display("FAIL vector_%0d got=%h/%b/%b exp=%h/%b/%b", i, diff[2], bout[2], ovf[2], e.diff, e.bout, e.ovf);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      int   c0, c;
      exp_t e;
      out_ready[2] = 1'b0;
      send(2, 8'h80, 8'h01, 1'b0, c0);
      wait_valid(2, c);
      e = exp_q[2].pop_front();
      for (int t = 0; t < 5; t++) begin
         checks += 3;
         if (out_valid[2] !== 1'b1 || in_ready[2] !== 1'b0) begin
            failures++;
            $display("FAIL bp_handshake t=%0d out_valid=%b in_ready=%b exp=1/0", t, out_valid[2], in_ready[2]);
         end
         if (diff[2] !== e.diff) begin
            failures++;
            $display("FAIL bp_diff t=%0d got=%h exp=%h", t, diff[2], e.diff);
         end
         if ({bout[2], ovf[2]} !== {e.bout, e.ovf}) begin
            failures++;
            $display("FAIL bp_flags t=%0d got=%b%b exp=%b%b", t, bout[2], ovf[2], e.bout, e.ovf);
         end
         in_valid[2] = t[0];
         op_a[2]     = 8'hC3;
         @(negedge clk);
      end
      in_valid[2]  = 1'b0;
      out_ready[2] = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready[2] !== 1'b1 || out_valid[2] !== 1'b0) begin
         failures++;
         $display("FAIL bp_release in_ready=%b out_valid=%b exp=1/0", in_ready[2], out_valid[2]);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (out_valid[2] !== 1'b0 || in_ready[2] !== 1'b1) begin
         failures++;
         $display("FAIL bp_ignored_pulse out_valid=%b in_ready=%b exp=0/1", out_valid[2], in_ready[2]);
      end
   endtask

   task automatic test_reset_mid_op();
      int   c0, c;
      exp_t e;
      send(2, 8'hF0, 8'h0F, 1'b1, c0);
      @(negedge clk);
      rst = 1'b1;
      void'(exp_q[2].pop_back());
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (out_valid[2] !== 1'b0 || diff[2] !== 8'h00 || in_ready[2] !== 1'b1) begin
         failures++;
         $display("FAIL midrst_state out_valid=%b diff=%h in_ready=%b exp=0/00/1", out_valid[2], diff[2], in_ready[2]);
      end
      send(2, 8'h05, 8'h03, 1'b0, c0);
      wait_valid(2, c);
      e = exp_q[2].pop_front();
      checks++;
      if ({diff[2], bout[2], ovf[2]} !== {e.diff, e.bout, e.ovf}) begin
         failures++;
         $display("FAIL midrst_newop got=%h/%b/%b exp=%h/%b/%b", diff[2], bout[2], ovf[2], e.diff, e.bout, e.ovf);
      end
      @(negedge clk);
   endtask

   task automatic test_chunk1();
      int   c0, c;
      exp_t e;
      send(0, 8'hFF, 8'hFF, 1'b1, c0);
      wait_valid(0, c);
      e = exp_q[0].pop_front();
      checks += 2;
      if (c - c0 !== 9) begin
         failures++;
         $display("FAIL chunk1_latency got=%0d exp=9", c - c0);
      end
      if ({diff[0], bout[0], ovf[0]} !== {e.diff, e.bout, e.ovf}) begin
         failures++;
         $display("FAIL chunk1_result got=%h/%b/%b exp=%h/%b/%b", diff[0], bout[0], ovf[0], e.diff, e.bout, e.ovf);
      end
      @(negedge clk);
   endtask

   task automatic run_random(input int k);
      int   c0, c, n;
      exp_t e;
      for (int i = 0; i < 25; i++) begin
         send(k, 8'($urandom), 8'($urandom), 1'($urandom), c0);
         wait_valid(k, c);
         checks++;
         if (c - c0 !== NSL[k] + 1) begin
            failures++;
            $display("FAIL rand_latency k=%0d got=%0d exp=%0d", k, c - c0, NSL[k] + 1);
         end
         n = 0;
         out_ready[k] = 1'($urandom);
         while (!out_ready[k] && n < 10) begin
            @(negedge clk);
            out_ready[k] = 1'($urandom);
            n++;
         end
         out_ready[k] = 1'b1;
         e = exp_q[k].pop_front();
         checks++;
         if (out_valid[k] !== 1'b1 || {diff[k], bout[k], ovf[k]} !== {e.diff, e.bout, e.ovf}) begin
            failures++;
            $display("FAIL rand_result k=%0d i=%0d v=%b got=%h/%b/%b exp=%h/%b/%b",
                     k, i, out_valid[k], diff[k], bout[k], ovf[k], e.diff, e.bout, e.ovf);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      fork
         run_random(0);
         run_random(1);
         run_random(2);
         run_random(3);
      join
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_vectors();
      test_backpressure();
      test_reset_mid_op();
      test_chunk1();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
